// File: rtl/iir_preemph.sv
// First-order IIR pre-emphasis filter: y[n] = DEQ(B0*x[n] + B1*x[n-1] + A1*y[n-1]),
// one sample in flight, a single multiplier shared across three MAC cycles.
module iir_preemph #(
  parameter int                           DATA_WIDTH = 32,
  parameter int                           QUANT_BITS = 10,
  parameter logic signed [DATA_WIDTH-1:0] B0         = 1024,
  parameter logic signed [DATA_WIDTH-1:0] B1         = -807,
  parameter logic signed [DATA_WIDTH-1:0] A1         = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = PROD_W + 2;
  localparam logic signed [ACC_W-1:0] ROUND_BIAS =
    {{(ACC_W - QUANT_BITS){1'b0}}, {QUANT_BITS{1'b1}}};

  typedef enum logic [2:0] {
    IDLE,
    MAC0,
    MAC1,
    MAC2,
    WRITE
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] x1;
  logic signed [DATA_WIDTH-1:0] y;
  logic signed [DATA_WIDTH-1:0] y1;
  logic signed [DATA_WIDTH-1:0] coef;
  logic signed [DATA_WIDTH-1:0] operand;
  logic signed [PROD_W-1:0]     product;
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      acc_base;
  logic signed [ACC_W-1:0]      acc_sum;
  logic signed [ACC_W-1:0]      acc_rounded;
  logic        [DATA_WIDTH-1:0] y_deq;

  // Operand selection for the shared multiplier, one term per MAC cycle
  always_comb begin
    coef    = B0;
    operand = x;
    case (state)
      MAC1: begin
        coef    = B1;
        operand = x1;
      end
      MAC2: begin
        coef    = A1;
        operand = y1;
      end
      default: begin
        coef    = B0;
        operand = x;
      end
    endcase
  end

  assign product  = PROD_W'(coef) * PROD_W'(operand);
  assign acc_base = (state == MAC0) ? '0 : acc;
  assign acc_sum  = acc_base + ACC_W'(product);

  // Biasing negative values before the arithmetic shift makes it truncate toward zero
  assign acc_rounded = acc_sum[ACC_W-1] ? (acc_sum + ROUND_BIAS) : acc_sum;
  assign y_deq       = DATA_WIDTH'(acc_rounded >>> QUANT_BITS);

  always_comb begin
    state_next = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    case (state)
      IDLE: begin
        in_rd_en = !reset && !in_empty;
        if (!in_empty) state_next = MAC0;
      end
      MAC0:  state_next = MAC1;
      MAC1:  state_next = MAC2;
      MAC2:  state_next = WRITE;
      WRITE: begin
        out_wr_en = !reset && !out_full;
        if (!out_full) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_din = y;

  // History only advances on a completed write, so a stalled sample leaves it intact
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      x     <= '0;
      x1    <= '0;
      y     <= '0;
      y1    <= '0;
      acc   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_rd_en) x <= in_dout;
        end
        MAC0, MAC1: acc <= acc_sum;
        MAC2: begin
          acc <= acc_sum;
          y   <= y_deq;
        end
        WRITE: begin
          if (out_wr_en) begin
            x1 <= x;
            y1 <= y;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_preemph.sv
// Scoreboard bench for iir_preemph: a default-coefficient instance and a
// feedback instance (B1=0, A1=512) share the same FIFO stimulus.
module tb_iir_preemph;

  localparam int DW = 32;
  localparam int QB = 10;
  localparam logic signed [DW-1:0] B0    = 1024;
  localparam logic signed [DW-1:0] B1    = -807;
  localparam logic signed [DW-1:0] A1    = 0;
  localparam logic signed [DW-1:0] FB_B0 = 1024;
  localparam logic signed [DW-1:0] FB_B1 = 0;
  localparam logic signed [DW-1:0] FB_A1 = 512;

  logic                 clock = 1'b0;
  logic                 reset;
  logic signed [DW-1:0] in_dout;
  logic                 in_empty;
  logic                 out_full;
  logic                 in_rd_en;
  logic                 out_wr_en;
  logic signed [DW-1:0] out_din;
  logic                 fb_rd_en;
  logic                 fb_wr_en;
  logic signed [DW-1:0] fb_out_din;

  always #5 clock = ~clock;

  iir_preemph #(.DATA_WIDTH(DW), .QUANT_BITS(QB), .B0(B0), .B1(B1), .A1(A1)) dut (
    .clock(clock), .reset(reset),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en)
  );

  iir_preemph #(.DATA_WIDTH(DW), .QUANT_BITS(QB), .B0(FB_B0), .B1(FB_B1), .A1(FB_A1)) dut_fb (
    .clock(clock), .reset(reset),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(fb_rd_en),
    .out_din(fb_out_din), .out_full(out_full), .out_wr_en(fb_wr_en)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int pops = 0;
  int writes = 0;
  int consumed = 0;
  bit rand_mode = 1'b0;
  bit hold_full = 1'b0;
  bit stalled = 1'b0;

  logic signed [DW-1:0] feed[$];
  logic signed [DW-1:0] exp0[$];
  logic signed [DW-1:0] exp1[$];
  logic signed [DW-1:0] obs0[$];
  logic signed [DW-1:0] obs1[$];
  int pop_cycles[$];
  int wr_cycles[$];
  logic signed [DW-1:0] h_x1 = 0, h_y1 = 0, f_x1 = 0, f_y1 = 0, pend_x = 0;
  logic signed [DW-1:0] e0, e1;

  task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                             input logic signed [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model: signed division truncates toward zero, then wraps to DW bits
  function automatic logic signed [DW-1:0] model(input logic signed [DW-1:0] b0, b1, a1,
                                                 input logic signed [DW-1:0] xn, xp, yp);
    logic signed [65:0] acc;
    acc = 66'(b0) * 66'(xn) + 66'(b1) * 66'(xp) + 66'(a1) * 66'(yp);
    acc = acc / (66'sd1 <<< QB);
    return acc[DW-1:0];
  endfunction

  task automatic applyStimulus(input logic signed [DW-1:0] sample);
    feed.push_back(sample);
  endtask

  task automatic waitWrites(input int target, input int budget);
    int k = 0;
    while (writes < target && k < budget) begin
      @(posedge clock);
      #1;
      k++;
    end
    checkOutput("write_count", writes, target);
  endtask

  // Upstream FIFO and downstream full model, updated just after each rising edge
  initial begin
    in_empty = 1'b1;
    in_dout  = '0;
    out_full = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      while (consumed < pops) begin
        if (feed.size() > 0) void'(feed.pop_front());
        consumed++;
      end
      in_empty = (rand_mode && ($urandom_range(0, 2) == 0)) || (feed.size() == 0);
      in_dout  = (feed.size() > 0) ? feed[0] : '0;
      out_full = rand_mode ? ($urandom_range(0, 3) == 0) : hold_full;
    end
  end

  // Monitor and scoreboard on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      cycle++;
      if (reset) begin
        exp0.delete();
        exp1.delete();
        h_x1 = 0; h_y1 = 0; f_x1 = 0; f_y1 = 0;
        checkOutput("rd_during_reset", in_rd_en, 0);
        checkOutput("wr_during_reset", out_wr_en, 0);
      end else begin
        if (in_rd_en && in_empty) checkOutput("rd_while_empty", in_rd_en, 0);
        if (fb_rd_en && in_empty) checkOutput("fb_rd_while_empty", fb_rd_en, 0);
        if (out_wr_en && out_full) checkOutput("wr_while_full", out_wr_en, 0);
        if (out_full) stalled = 1'b1;
        if (in_rd_en) begin
          pend_x = in_dout;
          exp0.push_back(model(B0, B1, A1, in_dout, h_x1, h_y1));
          exp1.push_back(model(FB_B0, FB_B1, FB_A1, in_dout, f_x1, f_y1));
          pop_cycles.push_back(cycle);
          pops++;
          stalled = out_full;
        end
        if (out_wr_en) begin
          if (exp0.size() == 0) checkOutput("write_without_pop", exp0.size(), 1);
          else begin
            e0 = exp0.pop_front();
            checkOutput("out_din", out_din, e0);
            obs0.push_back(out_din);
            if (!stalled) checkOutput("latency", cycle - pop_cycles[$], 4);
            h_x1 = pend_x;
            h_y1 = e0;
            wr_cycles.push_back(cycle);
            writes++;
          end
        end
        if (fb_wr_en) begin
          if (exp1.size() == 0) checkOutput("fb_write_without_pop", exp1.size(), 1);
          else begin
            e1 = exp1.pop_front();
            checkOutput("fb_out_din", fb_out_din, e1);
            obs1.push_back(fb_out_din);
            f_x1 = pend_x;
            f_y1 = e1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  int b, b1, p0, w0, k, pbase, wbase;
  int imp[4] = '{1024, -807, 0, 0};
  logic signed [DW-1:0] s[8];

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_out_din", out_din, 0);
    checkOutput("reset_fb_out_din", fb_out_din, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Positive impulse: FIR response on dut, halving decay on dut_fb
    b = obs0.size(); b1 = obs1.size(); p0 = pops; w0 = writes;
    applyStimulus(1024);
    repeat (12) applyStimulus(0);
    waitWrites(w0 + 13, 200);
    repeat (10) @(posedge clock);
    checkOutput("impulse_pops", pops - p0, 13);
    for (int i = 0; i < 4; i++) checkOutput("impulse", obs0[b + i], imp[i]);
    for (int i = 0; i < 13; i++) checkOutput("fb_decay", obs1[b1 + i], (i <= 10) ? (1024 >>> i) : 0);

    // Negative impulse: decay must end at 0, not a -1 limit cycle
    b = obs0.size(); b1 = obs1.size(); w0 = writes;
    applyStimulus(-1024);
    repeat (12) applyStimulus(0);
    waitWrites(w0 + 13, 200);
    checkOutput("neg_impulse_0", obs0[b], -1024);
    checkOutput("neg_impulse_1", obs0[b + 1], 807);
    for (int i = 0; i < 13; i++) checkOutput("fb_neg_decay", obs1[b1 + i], (i <= 10) ? -(1024 >>> i) : 0);

    // Truncation toward zero
    b = obs0.size(); w0 = writes;
    applyStimulus(1); applyStimulus(0); applyStimulus(-3000); applyStimulus(0);
    waitWrites(w0 + 4, 100);
    checkOutput("trunc_1", obs0[b], 1);
    checkOutput("trunc_neg807", obs0[b + 1], 0);
    checkOutput("trunc_m3000", obs0[b + 2], -3000);
    checkOutput("trunc_2364", obs0[b + 3], 2364);

    // Backpressure held for 20 cycles in WRITE
    hold_full = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    b = obs0.size(); w0 = writes;
    applyStimulus(5000); applyStimulus(7000);
    repeat (10) @(posedge clock);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checkOutput("bp_wr_en", out_wr_en, 0);
      checkOutput("bp_rd_en", in_rd_en, 0);
      checkOutput("bp_out_din", out_din, 5000);
    end
    @(posedge clock);
    #1 hold_full = 1'b0;
    waitWrites(w0 + 2, 100);
    checkOutput("bp_first", obs0[b], 5000);
    checkOutput("bp_history", obs0[b + 1], 3059);

    // Random starvation and random downstream full
    w0 = writes;
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++)
      applyStimulus((i % 2 == 0) ? $signed($urandom) : $signed(32'($urandom_range(0, 200000))) - 100000);
    waitWrites(w0 + 40, 2000);
    rand_mode = 1'b0;
    repeat (4) @(posedge clock);
    #1;

    // Throughput: 100 back-to-back samples within 500 cycles
    pbase = pop_cycles.size(); wbase = wr_cycles.size(); w0 = writes;
    for (int i = 0; i < 100; i++) applyStimulus($signed(32'($urandom_range(0, 200000))) - 100000);
    waitWrites(w0 + 100, 600);
    checkOutput("throughput", wr_cycles[wbase + 99] - pop_cycles[pbase], 499);

    // Reset during MAC1 of the fifth sample
    repeat (3) @(posedge clock);
    #1;
    p0 = pops; w0 = writes;
    for (int i = 0; i < 8; i++) begin
      s[i] = $signed(32'($urandom_range(0, 200000))) - 100000;
      applyStimulus(s[i]);
    end
    k = 0;
    while (pops < p0 + 5 && k < 100) begin
      @(posedge clock);
      #1;
      k++;
    end
    checkOutput("midreset_pops", pops - p0, 5);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    checkOutput("midreset_writes", writes - w0, 4);
    @(negedge clock);
    checkOutput("midreset_out_din", out_din, 0);
    b = obs0.size(); b1 = obs1.size();
    waitWrites(writes + 3, 100);
    checkOutput("post_reset_first", obs0[b], s[5]);
    checkOutput("fb_post_reset_first", obs1[b1], s[5]);

    repeat (5) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
